// File: rtl/dbg_guv_log_arb_pkg.sv
// ---------------------------------------------------------------------------
// dbg_guv_log_arb_pkg
//
// Shared definitions for the dbg_guv log arbiter:
//   - DBG_GUV_LOG_FLIT_W  : width of one log/receipt flit (32 bits)
//   - DBG_GUV_LOG_SLICE   : selects source i's flit from a flattened bus
//   - DBG_GUV_AXIS_FLIT   : AXI-Stream handshake (flit moves when valid & ready)
//   - LOG_FLIT_W          : package-level copy of the flit width
//   - arb_state_e         : arbiter lock state
//
// No ports; this file is compiled ahead of the modules that import it.
// ---------------------------------------------------------------------------
`ifndef DBG_GUV_LOG_ARB_PKG_SV
`define DBG_GUV_LOG_ARB_PKG_SV

`define DBG_GUV_LOG_FLIT_W 32
`define DBG_GUV_LOG_SLICE(bus, i) bus[`DBG_GUV_LOG_FLIT_W*(i) +: `DBG_GUV_LOG_FLIT_W]
`define DBG_GUV_AXIS_FLIT(valid, ready) ((valid) && (ready))

package dbg_guv_log_arb_pkg;

    localparam int LOG_FLIT_W = `DBG_GUV_LOG_FLIT_W;

    // UNLOCKED: round-robin pick among valid sources.
    // LOCKED:   one source owns the output until its TLAST flit is accepted.
    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

endpackage

`endif

// File: rtl/dbg_guv_log_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// dbg_guv_log_arb_rr_pick
//
// Purely combinational round-robin picker. Scans the request vector starting
// at ptr and wrapping modulo N; returns the first requesting index.
//
// Parameters:
//   N  number of requesters
//   W  index width (2^W >= N)
// Ports:
//   req          in   N  request vector
//   ptr          in   W  highest-priority index (must be < N)
//   grant        out  W  index of the winning requester (0 when none)
//   grant_valid  out  1  at least one request present
// ---------------------------------------------------------------------------
module dbg_guv_log_arb_rr_pick
    import dbg_guv_log_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         grant_valid
);

    // One extra bit so ptr + k can exceed N before the modulo fold.
    logic [W:0] cand;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (W+1)'(k);
            if (cand >= (W+1)'(N)) begin
                cand = cand - (W+1)'(N);
            end
            if (!grant_valid && req[cand[W-1:0]]) begin
                grant       = cand[W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbg_guv_log_arb.sv
// ---------------------------------------------------------------------------
// dbg_guv_log_arb
//
// Packet-aware round-robin arbiter merging N_IN 32-bit log streams into one.
// A source that wins keeps the grant until its TLAST flit is accepted. The
// output is a single register stage (1-cycle latency, full throughput);
// in_TREADY depends combinationally on out_TREADY.
//
// Optional feature (macro DBG_GUV_LOG_ARB_TIMEOUT_EN): a stall watchdog that
// releases a lock whose owner has held TVALID low for 2^TIMEOUT_W-1 cycles
// and sets the sticky 'dropped' flag. Without the macro, 'dropped' is 0.
//
// Parameters: N_IN (2..16), SRC_W (2^SRC_W >= N_IN), TIMEOUT_W.
// Ports:
//   clk         in   1          clock
//   rst         in   1          asynchronous reset, active-low
//   in_TDATA    in   32*N_IN    flattened source data, source i at [32i+31:32i]
//   in_TVALID   in   N_IN       per-source valid
//   in_TREADY   out  N_IN       per-source ready
//   in_TLAST    in   N_IN       per-source end of packet
//   out_TDATA   out  32         merged data
//   out_TVALID  out  1          output valid
//   out_TREADY  in   1          downstream ready
//   out_TLAST   out  1          end of packet
//   out_TDEST   out  SRC_W      source index of the flit
//   dropped     out  1          sticky watchdog-release flag
// ---------------------------------------------------------------------------
module dbg_guv_log_arb
    import dbg_guv_log_arb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int SRC_W     = 2,
    parameter int TIMEOUT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LOG_FLIT_W*N_IN-1:0] in_TDATA,
    input  logic [N_IN-1:0]            in_TVALID,
    output logic [N_IN-1:0]            in_TREADY,
    input  logic [N_IN-1:0]            in_TLAST,
    output logic [LOG_FLIT_W-1:0]      out_TDATA,
    output logic                       out_TVALID,
    input  logic                       out_TREADY,
    output logic                       out_TLAST,
    output logic [SRC_W-1:0]           out_TDEST,
    output logic                       dropped
);

    arb_state_e             state;
    arb_state_e             state_next;
    logic [SRC_W-1:0]       ptr;
    logic [SRC_W-1:0]       ptr_next;
    logic [SRC_W-1:0]       lock_src;
    logic [SRC_W-1:0]       lock_src_next;

    logic [SRC_W-1:0]       pick_idx;
    logic                   pick_valid;

    logic [SRC_W-1:0]       g;
    logic                   g_active;
    logic [LOG_FLIT_W-1:0]  g_data;
    logic                   g_last;
    logic                   g_valid;

    logic                   slot_free;
    logic                   accept;
    logic                   wd_expire;

    dbg_guv_log_arb_rr_pick #(
        .N (N_IN),
        .W (SRC_W)
    ) u_pick (
        .req         (in_TVALID),
        .ptr         (ptr),
        .grant       (pick_idx),
        .grant_valid (pick_valid)
    );

    // The output register can take a new flit when it is empty or draining.
    assign slot_free = !out_TVALID || out_TREADY;

    // Granted source: the round-robin winner when unlocked, the owner when
    // locked. A locked owner stays granted even while its TVALID is low.
    always_comb begin
        g        = pick_idx;
        g_active = pick_valid;
        if (state == ARB_LOCKED) begin
            g        = lock_src;
            g_active = 1'b1;
        end
    end

    // Mux the granted source's flit; other sources' data/last are ignored.
    always_comb begin
        g_data  = '0;
        g_last  = 1'b0;
        g_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (g == SRC_W'(i)) begin
                g_data  = `DBG_GUV_LOG_SLICE(in_TDATA, i);
                g_last  = in_TLAST[i];
                g_valid = in_TVALID[i];
            end
        end
    end

    // Output process: only the granted source sees ready, and nobody does
    // while reset is asserted.
    always_comb begin
        in_TREADY = '0;
        if (rst && g_active && slot_free) begin
            for (int i = 0; i < N_IN; i++) begin
                if (g == SRC_W'(i)) begin
                    in_TREADY[i] = 1'b1;
                end
            end
        end
    end

    assign accept = `DBG_GUV_AXIS_FLIT(g_valid, |in_TREADY);

    // Next-state process: a TLAST acceptance ends the packet and advances the
    // pointer past the winner; any other acceptance locks onto the winner.
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        lock_src_next = lock_src;
        if (accept) begin
            if (g_last) begin
                state_next = ARB_UNLOCKED;
                ptr_next   = (g == SRC_W'(N_IN-1)) ? '0 : g + 1'b1;
            end else begin
                state_next    = ARB_LOCKED;
                lock_src_next = g;
            end
        end else if (wd_expire) begin
            state_next = ARB_UNLOCKED;
            ptr_next   = (lock_src == SRC_W'(N_IN-1)) ? '0 : lock_src + 1'b1;
        end
    end

    // State register process.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_UNLOCKED;
            ptr      <= '0;
            lock_src <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            lock_src <= lock_src_next;
        end
    end

    // Output register: load on acceptance, empty when drained with nothing
    // new, and hold every field while stalled by the downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_TVALID <= 1'b0;
            out_TDATA  <= '0;
            out_TLAST  <= 1'b0;
            out_TDEST  <= '0;
        end else if (slot_free) begin
            if (accept) begin
                out_TVALID <= 1'b1;
                out_TDATA  <= g_data;
                out_TLAST  <= g_last;
                out_TDEST  <= g;
            end else begin
                out_TVALID <= 1'b0;
            end
        end
    end

`ifdef DBG_GUV_LOG_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    logic [TIMEOUT_W-1:0] wd_cnt;

    // Release fires on the cycle the count would reach 2^TIMEOUT_W-1.
    assign wd_expire = (state == ARB_LOCKED) && !g_valid && (wd_cnt == WD_LAST);

    // Watchdog counts owner-idle cycles while locked; cleared by any accepted
    // flit and whenever the arbiter is not locked, so each lock starts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (accept || state != ARB_LOCKED || wd_expire) begin
            wd_cnt <= '0;
        end else if (!g_valid) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky until reset so the host can tell a packet was truncated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropped <= 1'b0;
        end else if (wd_expire) begin
            dropped <= 1'b1;
        end
    end
`else
    logic [TIMEOUT_W-1:0] unused_timeout_w;

    assign unused_timeout_w = '0;
    assign wd_expire        = 1'b0;
    assign dropped          = 1'b0;
`endif

endmodule
